// File: rtl/uart_debug_ctrl.sv
// ASCII hex command controller between a UART rx/tx pair and a byte-wide debug bus.
// Host lines: "W<addr><dd>" writes, "R<addr>" reads, terminated by CR or LF.
// Replies: "K\r\n" (write ok), "<HH>\r\n" (read data), "!\r\n" (bus timeout), "?\r\n" (syntax error).
// Receiver handshake: rx_read is a one-cycle pulse that consumes the byte on rx_data.
// The receiver drops rx_ready one cycle late, so the cycle after a pulse is never consumed.
// Transmitter handshake: tx_new_data pulses only while tx_done=1. The next byte waits until
// tx_done has been seen low and then high again.
module uart_debug_ctrl #(
  parameter int ADDR_NIBBLES = 4,
  parameter int BUS_TIMEOUT  = 255,
  localparam int AW = 4 * ADDR_NIBBLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          rx_read,
  input  logic          tx_done,
  output logic          tx_new_data,
  output logic [7:0]    tx_data,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  output logic          bus_we,
  output logic          bus_re,
  input  logic [7:0]    bus_rdata,
  input  logic          bus_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_EOL, S_BUS, S_RESP
  } state_t;

  state_t        state, state_next;

  logic          skip;          // cycle after a consume: rx_ready is still stale
  logic [AW-1:0] addr_sh;
  logic [7:0]    wdata_sh;
  logic          wr;
  logic [7:0]    nib_cnt;
  logic          data_hi_done;
  logic [15:0]   tmo_cnt;
  logic [31:0]   rbuf;          // reply bytes, byte i at [8*i +: 8]
  logic [1:0]    ridx;
  logic [1:0]    rlast;
  logic          tx_wait_low;   // pulse sent, waiting for tx_done to drop

  logic          parsing, take, err;
  logic          is_hex, is_space, is_crlf, is_w, is_r;
  logic [3:0]    hex_val;
  logic          nib_last, tmo_last, reply_done;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Classify the byte currently offered by the receiver
  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)      hex_val = rx_data[3:0];
    else if (rx_data >= 8'h41 && rx_data <= 8'h46) hex_val = rx_data[3:0] + 4'd9;
    else if (rx_data >= 8'h61 && rx_data <= 8'h66) hex_val = rx_data[3:0] + 4'd9;
    else                                           is_hex  = 1'b0;
  end

  assign is_space   = (rx_data == 8'h20);
  assign is_crlf    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_w       = (rx_data == 8'h57) || (rx_data == 8'h77);
  assign is_r       = (rx_data == 8'h52) || (rx_data == 8'h72);
  assign parsing    = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA) || (state == S_EOL);
  assign rx_read    = parsing && rx_ready && !skip;
  assign take       = rx_read && !is_space;
  assign nib_last   = (nib_cnt == 8'(ADDR_NIBBLES - 1));
  assign tmo_last   = (tmo_cnt == 16'(BUS_TIMEOUT - 1));
  assign reply_done = tx_wait_low && !tx_done && (ridx == rlast);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and syntax error detection
  always_comb begin
    state_next = state;
    err        = 1'b0;
    unique case (state)
      S_IDLE: if (take && !is_crlf) begin
        if (is_w || is_r) state_next = S_ADDR;
        else              err        = 1'b1;
      end
      S_ADDR: if (take) begin
        if (!is_hex)       err        = 1'b1;
        else if (nib_last) state_next = wr ? S_DATA : S_EOL;
      end
      S_DATA: if (take) begin
        if (!is_hex)           err        = 1'b1;
        else if (data_hi_done) state_next = S_EOL;
      end
      S_EOL: if (take) begin
        if (is_crlf) state_next = S_BUS;
        else         err        = 1'b1;
      end
      S_BUS:  if (bus_ack || tmo_last) state_next = S_RESP;
      S_RESP: if (reply_done)          state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (err) state_next = S_RESP;
  end

  // Command shifters, bus strobes, reply buffer and transmitter sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip         <= 1'b1;
      addr_sh      <= '0;
      wdata_sh     <= '0;
      wr           <= 1'b0;
      nib_cnt      <= '0;
      data_hi_done <= 1'b0;
      tmo_cnt      <= '0;
      rbuf         <= '0;
      ridx         <= '0;
      rlast        <= '0;
      tx_wait_low  <= 1'b0;
      tx_new_data  <= 1'b0;
      tx_data      <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_we       <= 1'b0;
      bus_re       <= 1'b0;
    end else begin
      skip        <= rx_read;
      tx_new_data <= 1'b0;
      unique case (state)
        S_IDLE: if (take && (is_w || is_r)) begin
          wr           <= is_w;
          nib_cnt      <= '0;
          data_hi_done <= 1'b0;
          addr_sh      <= '0;
          wdata_sh     <= '0;
        end
        S_ADDR: if (take && is_hex) begin
          addr_sh <= (addr_sh << 4) | AW'(hex_val);
          nib_cnt <= nib_cnt + 8'd1;
        end
        S_DATA: if (take && is_hex) begin
          wdata_sh     <= {wdata_sh[3:0], hex_val};
          data_hi_done <= 1'b1;
        end
        S_EOL: if (take && is_crlf) begin
          bus_addr  <= addr_sh;
          bus_wdata <= wdata_sh;
          bus_we    <= wr;
          bus_re    <= !wr;
          tmo_cnt   <= '0;
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
            ridx        <= '0;
            tx_wait_low <= 1'b0;
            if (wr) begin
              rbuf  <= {8'h00, 8'h0A, 8'h0D, 8'h4B};
              rlast <= 2'd2;
            end else begin
              rbuf  <= {8'h0A, 8'h0D, hex_char(bus_rdata[3:0]), hex_char(bus_rdata[7:4])};
              rlast <= 2'd3;
            end
          end else if (tmo_last) begin
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
            ridx        <= '0;
            tx_wait_low <= 1'b0;
            rbuf        <= {8'h00, 8'h0A, 8'h0D, 8'h21};
            rlast       <= 2'd2;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (!tx_wait_low && tx_done) begin
            tx_new_data <= 1'b1;
            tx_data     <= rbuf[{ridx, 3'b000} +: 8];
            tx_wait_low <= 1'b1;
          end else if (tx_wait_low && !tx_done) begin
            tx_wait_low <= 1'b0;
            if (ridx != rlast) ridx <= ridx + 2'd1;
          end
        end
        default: ;
      endcase
      if (err) begin
        rbuf        <= {8'h00, 8'h0A, 8'h0D, 8'h3F};
        rlast       <= 2'd2;
        ridx        <= '0;
        tx_wait_low <= 1'b0;
      end
    end
  end

endmodule
